divider_4bit_seq: RTL



---
 rtl/divider_4bit_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/divider_4bit_seq.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock,
// using subtractor_4bit as the trial-subtraction stage.

module subtractor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] diff,
  output logic       cout
);
  logic [4:0] full;

  // cout=1 means no borrow, i.e. a >= b.
  assign full = {1'b0, a} - {1'b0, b};
  assign diff = full[3:0];
  assign cout = ~full[4];
endmodule

module divider_4bit_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       done,
  output logic       busy,
  output logic       dbz
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [3:0] acc_a;
  logic [3:0] q_reg;
  logic [3:0] d_reg;
  logic [1:0] count;

  logic [4:0] t;
  logic [3:0] diff;
  logic       cout;
  logic       ok;
  logic [3:0] a_next;
  logic [3:0] q_next;

  subtractor_4bit u_sub (
    .a    (t[3:0]),
    .b    (d_reg),
    .diff (diff),
    .cout (cout)
  );

  // When t[4] is set the trial subtraction always succeeds and the low four
  // bits of diff are the exact partial remainder.
  assign t      = {acc_a, q_reg[3]};
  assign ok     = t[4] | cout;
  assign a_next = ok ? diff : t[3:0];
  assign q_next = {q_reg[2:0], ok};

  assign done = (state == DONE);
  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_a     <= 4'd0;
      q_reg     <= 4'd0;
      d_reg     <= 4'd0;
      count     <= 2'd0;
      quotient  <= 4'd0;
      remainder <= 4'd0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor != 4'd0) begin
              acc_a <= 4'd0;
              q_reg <= dividend;
              d_reg <= divisor;
              count <= 2'd3;
              state <= RUN;
            end else begin
              quotient  <= 4'hF;
              remainder <= dividend;
              dbz       <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          acc_a <= a_next;
          q_reg <= q_next;
          count <= count - 2'd1;
          if (count == 2'd0) begin
            quotient  <= q_next;
            remainder <= a_next;
            dbz       <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
